// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the main-memory line arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int LINE_W_DEF = 128;
  localparam int TAG_W_DEF  = 9;

  localparam logic MEM_WE_READ  = 1'b0;
  localparam logic MEM_WE_WRITE = 1'b1;

  // Round-robin history: which requester was granted most recently
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_WB   = 3'd1,
    ST_D_RD   = 3'd2,
    ST_I_RD   = 3'd3,
    ST_FILL_D = 3'd4,
    ST_FILL_I = 3'd5
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates I-cache refills and D-cache refill/writebacks onto one
//            memory line port. Define ARB_RR_EN for round-robin tie-breaking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_miss,
  input  logic [TAG_W-1:0]  ic_miss_tag,
  output logic              ic_fill,
  output logic [LINE_W-1:0] ic_fill_line,
  output logic [TAG_W-1:0]  ic_fill_tag,
  input  logic              dc_miss,
  input  logic [TAG_W-1:0]  dc_miss_tag,
  input  logic              dc_wb,
  input  logic [TAG_W-1:0]  dc_wb_tag,
  input  logic [LINE_W-1:0] dc_wb_line,
  output logic              dc_fill,
  output logic [LINE_W-1:0] dc_fill_line,
  output logic [TAG_W-1:0]  dc_fill_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [TAG_W-1:0]  mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state_q, state_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic              wb_gap_q, wb_gap_d;
  logic [LINE_W-1:0] ic_line_q, ic_line_d;
  logic [TAG_W-1:0]  ic_tag_q, ic_tag_d;
  logic [LINE_W-1:0] dc_line_q, dc_line_d;
  logic [TAG_W-1:0]  dc_tag_q, dc_tag_d;
  logic              grant_dc, grant_ic;
`ifdef ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      miss_tag_q   <= '0;
      wb_tag_q     <= '0;
      wb_line_q    <= '0;
      wb_gap_q     <= 1'b0;
      ic_line_q    <= '0;
      ic_tag_q     <= '0;
      dc_line_q    <= '0;
      dc_tag_q     <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= GRANT_I;
`endif
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      wb_tag_q     <= wb_tag_d;
      wb_line_q    <= wb_line_d;
      wb_gap_q     <= wb_gap_d;
      ic_line_q    <= ic_line_d;
      ic_tag_q     <= ic_tag_d;
      dc_line_q    <= dc_line_d;
      dc_tag_q     <= dc_tag_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Grant decision, only meaningful while IDLE
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
`ifdef ARB_RR_EN
    if (dc_miss && ic_miss) begin
      grant_dc = (last_grant_q == GRANT_I);
      grant_ic = (last_grant_q == GRANT_D);
    end else begin
      grant_dc = dc_miss;
      grant_ic = ic_miss;
    end
`else
    grant_dc = dc_miss;
    grant_ic = !dc_miss && ic_miss;
`endif
  end

  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    wb_tag_d     = wb_tag_q;
    wb_line_d    = wb_line_q;
    wb_gap_d     = wb_gap_q;
    ic_line_d    = ic_line_q;
    ic_tag_d     = ic_tag_q;
    dc_line_d    = dc_line_q;
    dc_tag_d     = dc_tag_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    mem_req      = 1'b0;
    mem_we       = MEM_WE_READ;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_dc) begin
          miss_tag_d = dc_miss_tag;
`ifdef ARB_RR_EN
          last_grant_d = GRANT_D;
`endif
          if (dc_wb) begin
            wb_tag_d  = dc_wb_tag;
            wb_line_d = dc_wb_line;
            state_d   = ST_D_WB;
          end else begin
            state_d   = ST_D_RD;
          end
        end else if (grant_ic) begin
          miss_tag_d = ic_miss_tag;
`ifdef ARB_RR_EN
          last_grant_d = GRANT_I;
`endif
          state_d    = ST_I_RD;
        end
      end

      ST_D_WB: begin
        mem_req   = 1'b1;
        mem_we    = MEM_WE_WRITE;
        mem_addr  = wb_tag_q;
        mem_wdata = wb_line_q;
        if (mem_ready) begin
          wb_gap_d = 1'b1;
          state_d  = ST_D_RD;
        end
      end

      // The first D_RD cycle after a writeback is a dead cycle with no request
      ST_D_RD: begin
        if (wb_gap_q) begin
          wb_gap_d = 1'b0;
        end else begin
          mem_req  = 1'b1;
          mem_addr = miss_tag_q;
          if (mem_ready) begin
            dc_line_d = mem_rdata;
            dc_tag_d  = miss_tag_q;
            state_d   = ST_FILL_D;
          end
        end
      end

      ST_I_RD: begin
        mem_req  = 1'b1;
        mem_addr = miss_tag_q;
        if (mem_ready) begin
          ic_line_d = mem_rdata;
          ic_tag_d  = miss_tag_q;
          state_d   = ST_FILL_I;
        end
      end

      ST_FILL_D: state_d = ST_IDLE;
      ST_FILL_I: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign ic_fill      = (state_q == ST_FILL_I);
  assign ic_fill_line = ic_line_q;
  assign ic_fill_tag  = ic_tag_q;
  assign dc_fill      = (state_q == ST_FILL_D);
  assign dc_fill_line = dc_line_q;
  assign dc_fill_tag  = dc_tag_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between I-cache refills (fetch stage) and D-cache refills/writebacks (memory stage).
- Sequences each miss as a memory transaction with a req/ready handshake, then returns the line to the cache as a one-cycle fill pulse carrying line and tag.
- Sits between the fetch and memory stages and the memory model; the pipeline stalls on the miss levels while this block works.

Parameters:
- LINE_W, 128, cache line width in bits
- TAG_W, 9, line address/tag width; narrower requester tags are zero-extended at integration

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ic_miss  in  1  I-cache miss level, held until ic_fill
- ic_miss_tag  in  TAG_W  I-cache missing line address
- ic_fill  out  1  one-cycle I-cache write strobe
- ic_fill_line  out  LINE_W  refill data
- ic_fill_tag  out  TAG_W  refill tag
- dc_miss  in  1  D-cache miss level, held until dc_fill
- dc_miss_tag  in  TAG_W  D-cache missing line address
- dc_wb  in  1  victim dirty, sampled with dc_miss at grant
- dc_wb_tag  in  TAG_W  victim line address
- dc_wb_line  in  LINE_W  victim data
- dc_fill, dc_fill_line, dc_fill_tag  out  1/LINE_W/TAG_W  as for I-cache
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = line write, 0 = line read
- mem_addr  out  TAG_W  line address
- mem_wdata  out  LINE_W  write data
- mem_rdata  in  LINE_W  read data, valid when mem_ready is high
- mem_ready  in  1  completes the transaction in the cycle mem_req && mem_ready

Behaviour:
- Reset: async on rst_n low. State is IDLE. All outputs are 0, including the fill data and tag buses and mem_* outputs. A transaction in flight is abandoned, no fill is issued, and the requester re-requests because its miss level is still high.
- States are IDLE, D_WB, D_RD, I_RD, FILL_D and FILL_I.
- IDLE grant, sampled each clk edge:
  - dc_miss has priority over ic_miss; the memory stage holds the older instruction.
  - dc_miss && dc_wb: latch the wb tag and line, go to D_WB.
  - dc_miss && !dc_wb: go to D_RD.
  - else ic_miss: go to I_RD.
  - The miss tag is latched at grant. Later input changes are ignored until FILL.
- D_WB:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata come from the latched victim.
  - On mem_ready go to D_RD. mem_req drops for one cycle between the write and the read.
- D_RD / I_RD:
  - mem_req=1, mem_we=0, mem_addr is the latched miss tag.
  - On mem_ready, capture mem_rdata and go to FILL_D / FILL_I.
- FILL_x:
  - x_fill=1 for exactly one cycle with the captured line and tag.
  - Next state is IDLE.
  - Fill data and tag buses hold their last values afterwards; only the strobe returns to 0.
- Requester rule: the miss level must be low by the IDLE cycle after the fill.
- Latency with mem_ready tied high:
  - read miss to fill = 3 cycles (grant edge, req cycle, fill cycle).
  - writeback+read = 5 cycles.
- mem_ready is ignored while mem_req=0.
- A mem_ready stall of any length holds state and outputs stable.
- Simultaneous misses: D is served fully first. I is granted in the IDLE cycle after FILL_D.
- A miss that deasserts while its request is in flight (a flush) is still completed and filled; the cache drops a stale fill.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: a last_grant flag makes the grant round-robin when both misses are pending in IDLE; the requester not served last wins. The flag resets to I, so D wins the first tie.
- Undefined: fixed D-over-I priority; I can starve under back-to-back D misses.

Decomposition:
- Shared package mem_arb_pkg holds the state enum (arb_state_t), LINE_W/TAG_W defaults, and localparams for the mem_we encoding.
- No sub-module; one FSM plus capture registers. The round-robin flag stays inline under the macro.

Test Plan:
- Reset mid-D_RD (rst_n low for 2 cycles): all outputs read 0. After release with dc_miss still high, the block re-requests at the same mem_addr.
- ic_miss, tag 0x012, mem_ready=1, rdata=0xA5..A5: mem_req/mem_we=0/mem_addr=0x012 for one cycle, then ic_fill=1 with line 0xA5..A5 and tag 0x012 for exactly one cycle.
- dc_miss tag 0x1F0 with dc_wb tag 0x0C3, line 0x55..55:
  - a write to 0x0C3 with wdata 0x55..55 comes first;
  - then a read from 0x1F0 with mem_ready delayed 4 cycles, during which outputs stay stable;
  - then dc_fill tag 0x1F0.
- ic_miss and dc_miss raised in the same cycle: dc_fill precedes ic_fill. With ARB_RR_EN and a repeated tie, the second tie grants I.
- dc_miss dropped during D_RD: dc_fill is still pulsed once with the captured data, then the block returns to IDLE with no further mem_req.
